// File: rtl/frame_reader.sv
// Raster scan-out of a colour RAM into a 2-entry {x,y,colour} FIFO with a
// valid/ready pixel interface. Each RAM read carries its tag through the read latency.
module frame_reader #(
  parameter int WIDTH       = 160,
  parameter int HEIGHT      = 120,
  parameter int RAM_LATENCY = 1
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iStart,
  output logic [14:0] oRamAddr,
  input  logic [2:0]  iRamData,
  output logic [7:0]  oX,
  output logic [6:0]  oY,
  output logic [2:0]  oColour,
  output logic        oPlot,
  input  logic        iReady,
  output logic        oBusy,
  output logic        oDone
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed { logic [6:0] y; logic [7:0] x; } tag_t;
  typedef struct packed { logic [7:0] x; logic [6:0] y; logic [2:0] c; } pix_t;

  localparam logic [7:0] XLAST = 8'(WIDTH - 1);
  localparam logic [6:0] YLAST = 7'(HEIGHT - 1);

  state_t state, state_nxt;
  logic   done_nxt;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [14:0] addr_q;
  logic [RAM_LATENCY-1:0] vld_pipe;
  tag_t   tag_pipe [RAM_LATENCY];
  pix_t   fifo [2];
  logic   wp, rp;
  logic [1:0] cnt;
  logic [2:0] occ;
  logic   xfer, issue, last_addr, last_xfer, cap;
  tag_t   cap_tag;

  assign oPlot     = (cnt != 2'd0);
  assign xfer      = oPlot & iReady;
  assign cap       = vld_pipe[RAM_LATENCY-1];
  assign cap_tag   = tag_pipe[RAM_LATENCY-1];
  // A pop in this same cycle frees a slot, so it is subtracted before the limit test
  assign occ       = 3'(cnt) + 3'($countones(vld_pipe));
  assign issue     = (state == RUN) && ((occ - 3'(xfer)) < 3'd2);
  assign last_addr = (x == XLAST) && (y == YLAST);
  assign last_xfer = xfer && (cnt == 2'd1) && (vld_pipe == '0);
  assign oRamAddr  = issue ? {y, x} : addr_q;
  assign oBusy     = (state != IDLE);
  assign oX        = fifo[rp].x;
  assign oY        = fifo[rp].y;
  assign oColour   = fifo[rp].c;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:    if (iStart) state_nxt = RUN;
      RUN:     if (issue && last_addr) state_nxt = DRAIN;
      DRAIN:   if (last_xfer) begin
                 state_nxt = IDLE;
                 done_nxt  = 1'b1;
               end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state <= IDLE;
      oDone <= 1'b0;
    end else begin
      state <= state_nxt;
      oDone <= done_nxt;
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      x      <= '0;
      y      <= '0;
      addr_q <= '0;
    end else if (state == IDLE && iStart) begin
      x <= '0;
      y <= '0;
    end else if (issue) begin
      addr_q <= {y, x};
      if (x == XLAST) begin
        x <= '0;
        y <= (y == YLAST) ? 7'd0 : y + 7'd1;
      end else begin
        x <= x + 8'd1;
      end
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      vld_pipe <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= issue;
      tag_pipe[0] <= '{y: y, x: x};
      for (int i = 1; i < RAM_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      wp      <= 1'b0;
      rp      <= 1'b0;
      cnt     <= '0;
    end else begin
      if (cap) begin
        fifo[wp] <= '{x: cap_tag.x, y: cap_tag.y, c: iRamData};
        wp       <= ~wp;
      end
      if (xfer) rp <= ~rp;
      cnt <= cnt + 2'(cap) - 2'(xfer);
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// Scan-out bench: RAM model, raster-order scoreboard, address/occupancy tracking,
// stall stability, back-to-back frames and mid-frame reset.
module tb_frame_reader;
  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic        iClock = 1'b0;
  logic        iReset, iStart, iReady;
  logic [14:0] oRamAddr;
  logic [2:0]  iRamData;
  logic [7:0]  oX;
  logic [6:0]  oY;
  logic [2:0]  oColour;
  logic        oPlot, oBusy, oDone;
  logic [2:0]  ram [32768];

  frame_reader #(.WIDTH(W), .HEIGHT(H), .RAM_LATENCY(1)) dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart), .oRamAddr(oRamAddr),
    .iRamData(iRamData), .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot),
    .iReady(iReady), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 iClock = ~iClock;
  always @(posedge iClock) iRamData <= ram[oRamAddr];

  int checks = 0, errors = 0, iter = 0;
  int exp_idx = 0, iss_idx = 0, start_iter = 0, plot_lat = -1;
  logic busy_exp = 1'b0, done_exp = 1'b0, stall = 1'b0;
  logic [17:0] held = '0;
  logic [14:0] last_addr = '0;

  function automatic logic [14:0] addr_of(input int k);
    return {7'(k / W), 8'(k % W)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, sample 1ns later, advance the model
  // to what the next rising edge must do.
  task automatic step(input logic start, input logic rdy);
    logic fin, accept;
    @(negedge iClock);
    iStart = start;
    iReady = rdy;
    #1;
    iter++;
    if (stall) begin
      chk("hold_plot", 32'(oPlot), 32'd1);
      chk("hold_xyc", 32'({oX, oY, oColour}), 32'(held));
    end
    chk("busy", 32'(oBusy), 32'(busy_exp));
    chk("done", 32'(oDone), 32'(done_exp));
    if (oBusy && iss_idx < N && oRamAddr == addr_of(iss_idx)) begin
      iss_idx++;
      last_addr = oRamAddr;
    end else begin
      chk("addr_hold", 32'(oRamAddr), 32'(last_addr));
    end
    if (busy_exp && oPlot && plot_lat < 0) plot_lat = iter - start_iter - 1;
    fin = 1'b0;
    if (oPlot && rdy) begin
      chk("pix_xy", 32'({oY, oX}), 32'(addr_of(exp_idx)));
      chk("pix_colour", 32'(oColour), 32'(ram[addr_of(exp_idx)]));
      exp_idx++;
      fin = (exp_idx == N);
    end
    chk("occupancy", 32'((iss_idx - exp_idx) >= 0 && (iss_idx - exp_idx) <= 2), 32'd1);
    accept   = start && !busy_exp;
    stall    = oPlot && !rdy;
    held     = {oX, oY, oColour};
    done_exp = fin;
    if (fin) busy_exp = 1'b0;
    if (accept) begin
      busy_exp   = 1'b1;
      start_iter = iter;
      iss_idx    = 0;
      exp_idx    = 0;
      plot_lat   = -1;
    end
  endtask

  task automatic reset_now();
    iReset = 1'b1;
    iStart = 1'b0;
    iReady = 1'b0;
    #1;
    chk("rst_plot", 32'(oPlot), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_done", 32'(oDone), 32'd0);
    chk("rst_x", 32'(oX), 32'd0);
    chk("rst_y", 32'(oY), 32'd0);
    chk("rst_colour", 32'(oColour), 32'd0);
    chk("rst_addr", 32'(oRamAddr), 32'd0);
    stall = 1'b0; busy_exp = 1'b0; done_exp = 1'b0;
    last_addr = '0; iss_idx = 0; exp_idx = 0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic s, mid;
    int guard;
    for (int a = 0; a < 32768; a++) ram[a] = 3'(((a & 255) + (a >> 8)) % 8);
    iReset = 1'b0; iStart = 1'b0; iReady = 1'b0;
    #2;
    reset_now();
    @(negedge iClock);
    iReset = 1'b0;
    repeat (2) step(1'b0, 1'b1);

    // Frame A: ready held high, stray start at pixel 500, restart in the oDone cycle
    step(1'b1, 1'b1);
    mid = 1'b0;
    for (guard = 0; guard < 25000 && !done_exp; guard++) begin
      s = !mid && (exp_idx == 500);
      if (s) mid = 1'b1;
      step(s, 1'b1);
    end
    chk("A_first_plot", plot_lat, 2);
    chk("A_done_lat", iter - start_iter, N + 2);
    chk("A_count", exp_idx, N);
    for (int a = 0; a < 32768; a++) ram[a] = 3'($urandom_range(7));
    step(1'b1, 1'b1);

    // Frame B: random ready and random ignored starts
    for (guard = 0; guard < 60000 && !done_exp; guard++)
      step(1'($urandom_range(63) == 0), 1'($urandom_range(1)));
    chk("B_first_plot", plot_lat, 2);
    chk("B_count", exp_idx, N);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Frame C: 100-cycle stall after start, then reset while (37,5) is presented
    step(1'b1, 1'b0);
    repeat (100) step(1'b0, 1'b0);
    chk("C_issued", iss_idx, 2);
    chk("C_plot", 32'(oPlot), 32'd1);
    chk("C_none_out", exp_idx, 0);
    chk("C_addr_frozen", 32'(oRamAddr), 32'(addr_of(1)));
    step(1'b0, 1'b1);
    chk("C_resume_addr", 32'(oRamAddr), 32'(addr_of(2)));
    for (guard = 0; guard < 2000 && !(oPlot && oX == 8'd37 && oY == 7'd5); guard++)
      step(1'b0, 1'b1);
    chk("C_reached", 32'({oY, oX}), 32'({7'd5, 8'd37}));
    reset_now();
    @(negedge iClock);
    iReset = 1'b0;

    // Restart after reset must begin at (0,0)
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (guard = 0; guard < 1000 && exp_idx < 300; guard++)
      step(1'b0, 1'($urandom_range(1)));
    chk("R_first_plot", plot_lat, 2);
    chk("R_count", exp_idx, 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter WIDTH, default 160, pixels per row.
REQ-002 Parameter HEIGHT, default 120, rows per frame.
REQ-003 Parameter RAM_LATENCY, fixed at 1: colour RAM read data is valid one clock after the address is presented.
REQ-004 Port iClock, input, 1, sole clock; all state changes on its rising edge.
REQ-005 Port iReset, input, 1, asynchronous active-high reset.
REQ-006 Port iStart, input, 1, single-cycle request to scan out one frame.
REQ-007 Port oRamAddr, output, 15, colour RAM read address {y[6:0], x[7:0]}.
REQ-008 Port iRamData, input, 3, colour RAM read data for the address issued the previous cycle.
REQ-009 Port oX, output, 8, pixel x of the presented pixel.
REQ-010 Port oY, output, 7, pixel y of the presented pixel.
REQ-011 Port oColour, output, 3, colour of the presented pixel.
REQ-012 Port oPlot, output, 1, presented pixel valid.
REQ-013 Port iReady, input, 1, downstream accepts the presented pixel.
REQ-014 Port oBusy, output, 1, frame scan in progress.
REQ-015 Port oDone, output, 1, one-cycle pulse on frame completion.

Function
REQ-016 A pixel transfer occurs on each rising edge where oPlot=1 and iReady=1.
REQ-017 While oPlot=1 and iReady=0, oX, oY and oColour shall remain stable and oPlot shall stay 1.
REQ-018 States: IDLE, RUN, DRAIN.
- IDLE->RUN when iStart=1.
- RUN->DRAIN on the cycle the last address (x=WIDTH-1, y=HEIGHT-1) is issued.
- DRAIN->IDLE on the cycle the last pixel transfers.
REQ-019 iStart shall be ignored in RUN and DRAIN.
REQ-020 oBusy shall be 1 in RUN and DRAIN, and 0 in IDLE.
REQ-021 Scan order: x increments 0..WIDTH-1, then wraps to 0 with y+1; y runs 0..HEIGHT-1.
REQ-022 The address counters shall reset to x=0, y=0 on each IDLE->RUN transition.
REQ-023 Each read shall carry its {x,y} tag alongside it through the one-cycle RAM latency, so oX/oY always match the RAM address that produced oColour.
REQ-024 The output stage shall be a 2-entry FIFO of {x,y,colour}; oPlot shall equal FIFO not-empty.
REQ-025 A read shall issue in RUN only when FIFO occupancy plus reads in flight is less than 2, counting a same-cycle transfer as freeing an entry.
REQ-026 When no read issues, oRamAddr shall hold its last value.
REQ-027 With iReady held 1, sustained throughput shall be one pixel per clock.
REQ-028 With iReady held 1, the first oPlot shall assert 2 cycles after the iStart edge: address issued the cycle after iStart, data captured one cycle later.
REQ-029 Exactly WIDTH*HEIGHT transfers per frame, with no duplicates and no skips, under any iReady pattern.
REQ-030 oDone shall pulse 1 for exactly one cycle, the cycle after the final transfer, coincident with entry to IDLE.
REQ-031 If iStart=1 in the same cycle oDone=1, a new frame shall start: IDLE->RUN on that edge.
REQ-032 Counter compares shall use full-width equality against WIDTH-1 and HEIGHT-1; x/y outside range shall never be issued.

Reset
REQ-033 iReset=1 shall asynchronously force state IDLE and clear FIFO and in-flight tags.
REQ-034 Reset values: oPlot=0, oBusy=0, oDone=0, oX=0, oY=0, oColour=0, oRamAddr=0.
REQ-035 Reset mid-frame shall abandon the frame with no oDone pulse.
REQ-036 The first iStart after reset release shall begin at x=0, y=0.

Verification
REQ-037 iReady=1 and RAM model returning colour=(x+y)%8; pulse iStart -> 19200 transfers in raster order with correct colours, first oPlot 2 cycles after iStart, oDone 19202 cycles after iStart.
REQ-038 iReady toggling on a pseudo-random 50% pattern -> same 19200-pixel sequence, oX/oY/oColour stable while stalled, FIFO never exceeds 2 entries.
REQ-039 iReady=0 for 100 cycles after start -> exactly 2 pixels buffered, oRamAddr frozen; releasing iReady resumes at x=2, y=0 with no loss.
REQ-040 iStart pulsed again mid-frame at pixel 500 -> ignored, frame completes normally with a single oDone.
REQ-041 iReset asserted at pixel (37,5) -> oPlot, oBusy and oDone go 0 immediately; the next iStart restarts from (0,0).
REQ-042 iStart asserted in the oDone cycle -> back-to-back frame, oBusy low for at most one cycle, second frame fully correct.
